gray_slot_scheduler: RTL and testbench

Round-robin scheduler that shares one gray-code slot counter among NREQ requesters. A requester is granted exclusive ownership of the counter for a programmed number of ticks, sees the count in gray code, and gets a start marker and a completion pulse. It sits in front of the gray counter datapath and is the only block that starts, sequences and terminates counter runs.

---
 rtl/gray_sched_pkg.sv | 46 ++++
 rtl/gray_slot_cnt.sv | 42 ++++
 rtl/gray_slot_scheduler.sv | 112 +++++++++++
 tb/tb_gray_slot_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sched_pkg.sv
// rtl/gray_sched_pkg.sv - shared types and helpers for the gray slot scheduler
// Provides the FSM state type, the round-robin pick result type,
// bin2gray() and rr_pick(). No ports.
package gray_sched_pkg;

  localparam int MAX_NREQ  = 16;
  localparam int PTR_W     = 4;
  localparam int MAX_CBITS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // Callers cast the result back down to their own counter width.
  function automatic logic [MAX_CBITS-1:0] bin2gray(input logic [MAX_CBITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // First requester at or after ptr, wrapping at nreq. ptr < nreq, so a
  // single subtraction is enough to wrap the search index.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [PTR_W-1:0]    ptr,
                                       input int                  nreq);
    rr_pick_t         r;
    int               i;
    logic [PTR_W-1:0] ii;
    r = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      i = int'(ptr) + k;
      if (i >= nreq) i = i - nreq;
      ii = PTR_W'(i);
      if (k < nreq && !r.valid && req[ii]) begin
        r.valid = 1'b1;
        r.idx   = ii;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_slot_cnt.sv
// rtl/gray_slot_cnt.sv - slot counter with clear, enable and terminal compare
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         force count to 0 (wins over en)
//   en          advance count by one
//   len         terminal value
//   cnt         binary count
//   gray_c      gray code of cnt
//   at_end      cnt == len
module gray_slot_cnt
  import gray_sched_pkg::*;
#(
  parameter int CBITS = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CBITS-1:0] len,
  output logic [CBITS-1:0] cnt,
  output logic [CBITS-1:0] gray_c,
  output logic             at_end
);

  logic [CBITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CBITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign gray_c = CBITS'(bin2gray(MAX_CBITS'(cnt_q)));
  assign at_end = (cnt_q == len);

endmodule

// File: rtl/gray_slot_scheduler.sv
// rtl/gray_slot_scheduler.sv - round-robin owner of a shared gray slot counter
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   req         per-requester level request
//   req_len     packed slot lengths, requester i at [i*CBITS +: CBITS]
//   gnt         registered one-hot grant
//   busy        high in RUN
//   gray_c      gray code of the slot count, 0 outside RUN
//   sig         first cycle of a slot
//   done        last cycle of a slot
//   abort       owner dropped req before done
module gray_slot_scheduler
  import gray_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CBITS = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [CBITS-1:0]      gray_c,
  output logic                  sig,
  output logic                  done,
  output logic                  abort
);

  localparam int PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [CBITS-1:0] len_q, len_d;
  logic [CBITS-1:0] cnt, cnt_gray;
  logic             at_end, run, owner_req, cnt_en;
  logic [PW-1:0]    next_ptr;
  rr_pick_t         pick;

  assign run       = (state_q == RUN);
  assign owner_req = req[owner_q];
  assign pick      = rr_pick(MAX_NREQ'(req), PTR_W'(ptr_q), NREQ);
  assign next_ptr  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  // Counter only advances mid-slot; everywhere else it is held at 0 so
  // the next grant always starts from a clean count.
  assign cnt_en = run && owner_req && !at_end;

  gray_slot_cnt #(.CBITS(CBITS)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!cnt_en),
    .en     (cnt_en),
    .len    (len_q),
    .cnt    (cnt),
    .gray_c (cnt_gray),
    .at_end (at_end)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          state_d = RUN;
          owner_d = PW'(pick.idx);
          gnt_d   = NREQ'(1) << pick.idx;
          len_d   = req_len[pick.idx*CBITS +: CBITS];
        end
      end
      RUN: begin
        // Abort and done both end the slot the same way.
        if (!owner_req || at_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = run;
  assign gray_c = run ? cnt_gray : '0;
  assign sig    = run && (cnt == '0);
  assign abort  = run && !owner_req;
  assign done   = run && owner_req && at_end;

endmodule

// File: tb/tb_gray_slot_scheduler.sv
// tb/tb_gray_slot_scheduler.sv - self-checking bench for gray_slot_scheduler
module tb_gray_slot_scheduler;

  localparam int NREQ  = 4;
  localparam int CBITS = 13;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [CBITS-1:0]      gray_c;
  logic                  sig;
  logic                  done;
  logic                  abort;

  int vectors    = 0;
  int miscompares = 0;

  // Reference: whether a slot is active, who owns it, count, length, pointer.
  int m_run   = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_len   = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  gray_slot_scheduler #(.NREQ(NREQ), .CBITS(CBITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .busy    (busy),
    .gray_c  (gray_c),
    .sig     (sig),
    .done    (done),
    .abort   (abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int c);
    return c ^ (c >> 1);
  endfunction

  task automatic set_len(input int i, input int v);
    req_len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  task automatic check_model();
    int own_req;
    own_req = (m_run != 0) ? int'(req[m_owner]) : 0;
    chk("gnt",   32'(gnt),    (m_run != 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy",  32'(busy),   32'(m_run));
    chk("gray",  32'(gray_c), (m_run != 0) ? 32'(gray_of(m_cnt)) : 32'd0);
    chk("sig",   32'(sig),    32'((m_run != 0) && m_cnt == 0));
    chk("done",  32'(done),   32'((m_run != 0) && own_req != 0 && m_cnt == m_len));
    chk("abort", 32'(abort),  32'((m_run != 0) && own_req == 0));
  endtask

  task automatic model_update();
    int i;
    if (!rst_n) begin
      m_run = 0; m_owner = 0; m_cnt = 0; m_len = 0; m_ptr = 0;
    end else if (m_run == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (m_run == 0 && req[i]) begin
          m_run = 1; m_owner = i; m_cnt = 0;
          m_len = int'(req_len[i*CBITS +: CBITS]);
        end
      end
    end else if (!req[m_owner] || m_cnt == m_len) begin
      m_run = 0;
      m_cnt = 0;
      m_ptr = (m_owner + 1) % NREQ;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Inputs are set by the caller just after a negedge; outputs are checked
  // against the model, then the edge is taken.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_gray[3];
    int g_idx[$];
    int g_cyc[$];
    logic [NREQ-1:0]  prev_gnt;
    logic [CBITS-1:0] prev_gray;

    rst_n   = 1'b0;
    req     = '0;
    req_len = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    step();
    chk("rst_gnt",  32'(gnt),    32'd0);
    chk("rst_busy", 32'(busy),   32'd0);
    chk("rst_gray", 32'(gray_c), 32'd0);

    // Requester 2, len 3
    set_len(2, 3);
    req = 4'b0100;
    step();
    chk("t1_gnt",  32'(gnt),    32'h4);
    chk("t1_sig",  32'(sig),    32'd1);
    chk("t1_gray", 32'(gray_c), 32'd0);
    exp_gray = '{1, 3, 2};
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t1_seq", 32'(gray_c), 32'(exp_gray[n]));
    end
    chk("t1_done", 32'(done), 32'd1);
    step();
    chk("t1_idle", 32'(gnt), 32'd0);
    req = '0;
    step();

    // len 0 on requester 0
    set_len(0, 0);
    req = 4'b0001;
    step();
    chk("t2_sig",  32'(sig),    32'd1);
    chk("t2_done", 32'(done),   32'd1);
    chk("t2_gray", 32'(gray_c), 32'd0);
    step();
    chk("t2_idle", 32'(gnt), 32'd0);
    req = '0;

    // Fairness with everyone requesting, len 1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req      = '1;
    prev_gnt = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt != '0 && prev_gnt == '0) begin
        for (int b = 0; b < NREQ; b++) if (gnt[b]) g_idx.push_back(b);
        g_cyc.push_back(c);
      end
      prev_gnt = gnt;
    end
    chk("t3_ngrants", 32'(g_idx.size() >= 5), 32'd1);
    if (g_idx.size() >= 5) begin
      for (int n = 0; n < 5; n++) begin
        chk("t3_order", 32'(g_idx[n]), 32'(n % NREQ));
        if (n > 0) chk("t3_spacing", 32'(g_cyc[n] - g_cyc[n-1]), 32'd3);
      end
    end

    // Owner drops req at cnt 2 of len 5
    do_reset();
    set_len(1, 5);
    req = 4'b0010;
    step();
    step();
    step();
    chk("t4_gray2", 32'(gray_c), 32'd3);
    req = '0;
    #1;
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_nodone", 32'(done), 32'd0);
    step();
    chk("t4_idle", 32'(gnt), 32'd0);
    req = '1;
    step();
    chk("t4_ptr", 32'(gnt), 32'h4);

    // Reset mid-run at cnt 7
    do_reset();
    set_len(3, 10);
    req = 4'b1000;
    for (int n = 0; n < 8; n++) step();
    chk("t5_gray7", 32'(gray_c), 32'd4);
    rst_n = 1'b0;
    step();
    chk("t5_gnt",  32'(gnt),    32'd0);
    chk("t5_busy", 32'(busy),   32'd0);
    chk("t5_gray", 32'(gray_c), 32'd0);
    chk("t5_done", 32'(done),   32'd0);
    rst_n = 1'b1;
    req   = '1;
    step();
    chk("t5_regrant", 32'(gnt), 32'h1);

    // Full-width walk of the gray sequence
    do_reset();
    set_len(0, (1 << CBITS) - 1);
    req = 4'b0001;
    step();
    prev_gray = gray_c;
    for (int n = 1; n < (1 << CBITS); n++) begin
      step();
      chk("t6_onebit", 32'($countones(gray_c ^ prev_gray)), 32'd1);
      prev_gray = gray_c;
    end
    chk("t6_done", 32'(done),   32'd1);
    chk("t6_last", 32'(gray_c), 32'h1000);
    req = '0;
    step();

    // Random traffic, including drops, length changes and resets
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NREQ; i++) begin
        set_len(i, $urandom_range(0, 6));
        if (m_run != 0 && i == m_owner) begin
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = ~req[i];
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
